ahb_apb_bridge: RTL and testbench

//  AHB-Lite slave to single-slave APB4 master. Sits directly upstream of the GPIO peripheral and drives its

---
 rtl/ahb_apb_bridge_if.sv | 46 ++++
 rtl/ahb_apb_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_ahb_apb_bridge.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_apb_bridge_if.sv
// rtl/ahb_apb_bridge_if.sv - AHB-Lite and APB4 signal bundle for the AHB-to-APB bridge
//
// Purpose: groups the AHB-Lite slave port and the APB4 master port of the bridge.
// Modports:
//   slave  - bridge view: AHB request/data in, AHB response out, APB request out, APB response in
//   master - environment view: drives the AHB request and the APB response, observes the rest
interface ahb_apb_bridge_if #(
    parameter int DATA_W     = 32,
    parameter int HADDR_W    = 32,
    parameter int PADDR_SIZE = 4
);
    logic                  HSEL;
    logic [HADDR_W-1:0]    HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [DATA_W-1:0]     HWDATA;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [DATA_W-1:0]     HRDATA;

    logic                  PSEL;
    logic                  PENABLE;
    logic [PADDR_SIZE-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W/8-1:0]   PSTRB;
    logic                  PREADY;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PSLVERR;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/ahb_apb_bridge.sv
// rtl/ahb_apb_bridge.sv - AHB-Lite slave to single-slave APB4 master bridge
//
// Purpose: converts each accepted AHB transfer into one APB SETUP+ACCESS sequence, stretching
//          the AHB data phase until PREADY and mapping PSLVERR / illegal transfers to a two-cycle
//          AHB ERROR response. All outputs are registered.
// Ports:
//   HCLK    - clock, rising edge
//   HRESETn - synchronous active-low reset
//   bus     - ahb_apb_bridge_if.slave: AHB HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY in,
//             HREADYOUT/HRESP/HRDATA out; APB PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB out,
//             PREADY/PRDATA/PSLVERR in
// Optional feature: APB_BRIDGE_TIMEOUT_EN - abort an ACCESS after TIMEOUT_CYCLES wait cycles.
module ahb_apb_bridge #(
    parameter int DATA_W         = 32,
    parameter int HADDR_W        = 32,
    parameter int PADDR_SIZE     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahb_apb_bridge_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t                state_q, state_d;
    logic [PADDR_SIZE+1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [PADDR_SIZE-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_W-1:0]     pwdata_q, pwdata_d;
    logic [DATA_W/8-1:0]   pstrb_q, pstrb_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;
    logic [DATA_W-1:0]     hrdata_q, hrdata_d;

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]            wait_cnt_q, wait_cnt_d;
`endif

    logic                  accept;
    logic                  legal;
    logic [DATA_W/8-1:0]   wr_strb;
    logic                  unused_bits;

    assign unused_bits = ^{bus.HTRANS[0], bus.HADDR[HADDR_W-1:PADDR_SIZE+2], 8'(TIMEOUT_CYCLES)};

    // HREADYOUT is high only in IDLE and ERR2, which are exactly the states that may accept.
    assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY & hreadyout_q;

    always_comb begin
        case (bus.HSIZE)
            3'd0:    legal = 1'b1;
            3'd1:    legal = ~bus.HADDR[0];
            3'd2:    legal = (bus.HADDR[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (size_q)
            3'd0:    wr_strb = 4'b0001 << addr_q[1:0];
            3'd1:    wr_strb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: wr_strb = 4'b1111;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        size_d      = size_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
`ifdef APB_BRIDGE_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            IDLE, ERR2: begin
                state_d     = IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                if (accept) begin
                    addr_d      = bus.HADDR[PADDR_SIZE+1:0];
                    write_d     = bus.HWRITE;
                    size_d      = bus.HSIZE;
                    hreadyout_d = 1'b0;
                    // Illegal transfers skip the APB side and enter ERR1 with HRESP already up.
                    state_d     = legal ? SETUP : ERR1;
                    hresp_d     = ~legal;
                end
            end
            SETUP: begin
                // First SETUP cycle is the AHB data phase; HWDATA is only valid at its end,
                // so the APB setup phase is launched from that edge.
                if (!psel_q) begin
                    psel_d   = 1'b1;
                    paddr_d  = addr_q[PADDR_SIZE+1:2];
                    pwrite_d = write_q;
                    pwdata_d = bus.HWDATA;
                    pstrb_d  = write_q ? wr_strb : '0;
                end else begin
                    penable_d = 1'b1;
                    state_d   = ACCESS;
`ifdef APB_BRIDGE_TIMEOUT_EN
                    wait_cnt_d = 8'd0;
`endif
                end
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (bus.PSLVERR) begin
                        state_d = ERR1;
                        hresp_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        hreadyout_d = 1'b1;
                        hresp_d     = 1'b0;
                        if (!write_q) hrdata_d = bus.PRDATA;
                    end
                end
`ifdef APB_BRIDGE_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = ERR1;
                    hresp_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            ERR1: begin
                state_d     = ERR2;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 3'd0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
            wait_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
`ifdef APB_BRIDGE_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb/tb_ahb_apb_bridge.sv - directed self-checking bench for ahb_apb_bridge
module tb_ahb_apb_bridge;
`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    ahb_apb_bridge_if bus ();

    ahb_apb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] addr, input logic wr, input logic [2:0] size);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr; bus.HWRITE = wr; bus.HSIZE = size;
    endtask

    task automatic end_addr_phase();
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    endtask

    // Driver only: runs one transfer with the current PREADY/PSLVERR and reports what it saw.
    task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic [31:0] wdata, output logic [3:0] strb,
                            output logic psel_seen, output logic err, output int lat);
        addr_phase(addr, wr, size);
        step();
        end_addr_phase();
        bus.HWDATA = wdata;
        strb = 4'h0; psel_seen = 1'b0; err = 1'b0; lat = 0;
        while (!bus.HREADYOUT && lat < 50) begin
            if (bus.PSEL) begin psel_seen = 1'b1; strb = bus.PSTRB; end
            if (bus.HRESP) err = 1'b1;
            step();
            lat++;
        end
        if (bus.HRESP) err = 1'b1;
    endtask

    task automatic test_reset();
        bus.HSEL = 0; bus.HADDR = 0; bus.HTRANS = 0; bus.HWRITE = 0; bus.HSIZE = 0; bus.HWDATA = 0;
        bus.HREADY = 1; bus.PREADY = 1; bus.PRDATA = 0; bus.PSLVERR = 0;
        HRESETn = 1'b0;
        step(); step();
        tests++; if (bus.PSEL !== 1'b0) begin fails++; $display("FAIL rst_psel: got %0h want 0", bus.PSEL); end
        tests++; if (bus.PENABLE !== 1'b0) begin fails++; $display("FAIL rst_penable: got %0h want 0", bus.PENABLE); end
        tests++; if (bus.HREADYOUT !== 1'b1) begin fails++; $display("FAIL rst_hreadyout: got %0h want 1", bus.HREADYOUT); end
        tests++; if (bus.HRESP !== 1'b0) begin fails++; $display("FAIL rst_hresp: got %0h want 0", bus.HRESP); end
        tests++; if (bus.HRDATA !== 32'h0) begin fails++; $display("FAIL rst_hrdata: got %0h want 0", bus.HRDATA); end
        tests++; if ({bus.PADDR, bus.PSTRB, bus.PWDATA, bus.PWRITE} !== 41'h0) begin fails++; $display("FAIL rst_apb_regs: got %0h want 0", {bus.PADDR, bus.PSTRB, bus.PWDATA, bus.PWRITE}); end
        HRESETn = 1'b1;
        step();
    endtask

    task automatic test_idle_busy();
        bus.HSEL = 1'b1; bus.HADDR = 32'h4; bus.HWRITE = 1'b1; bus.HSIZE = 3'd2;
        bus.HTRANS = 2'b00;
        step();
        tests++; if ({bus.HREADYOUT, bus.HRESP, bus.PSEL} !== 3'b100) begin fails++; $display("FAIL idle_trans: got %b want 100", {bus.HREADYOUT, bus.HRESP, bus.PSEL}); end
        bus.HTRANS = 2'b01;
        step(); step();
        tests++; if ({bus.HREADYOUT, bus.HRESP, bus.PSEL} !== 3'b100) begin fails++; $display("FAIL busy_trans: got %b want 100", {bus.HREADYOUT, bus.HRESP, bus.PSEL}); end
        end_addr_phase();
    endtask

    task automatic test_word_write();
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
        addr_phase(32'h4, 1'b1, 3'd2);
        step();
        end_addr_phase();
        bus.HWDATA = 32'hA5A5_0F0F;
        tests++; if ({bus.HREADYOUT, bus.PSEL} !== 2'b00) begin fails++; $display("FAIL wr_accept: got %b want 00", {bus.HREADYOUT, bus.PSEL}); end
        step();
        tests++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b101) begin fails++; $display("FAIL wr_setup_ctl: got %b want 101", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
        tests++; if (bus.PADDR !== 4'd1) begin fails++; $display("FAIL wr_paddr: got %0h want 1", bus.PADDR); end
        tests++; if (bus.PSTRB !== 4'hF) begin fails++; $display("FAIL wr_pstrb: got %0h want f", bus.PSTRB); end
        tests++; if (bus.PWDATA !== 32'hA5A5_0F0F) begin fails++; $display("FAIL wr_pwdata: got %0h want a5a50f0f", bus.PWDATA); end
        bus.HWDATA = 32'h0;
        step();
        tests++; if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT} !== 3'b110) begin fails++; $display("FAIL wr_access: got %b want 110", {bus.PSEL, bus.PENABLE, bus.HREADYOUT}); end
        tests++; if (bus.PWDATA !== 32'hA5A5_0F0F) begin fails++; $display("FAIL wr_pwdata_hold: got %0h want a5a50f0f", bus.PWDATA); end
        step();
        tests++; if ({bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE} !== 4'b1000) begin fails++; $display("FAIL wr_done: got %b want 1000", {bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE}); end
    endtask

    task automatic test_read_wait();
        int pen_cnt = 0;
        int lat = 0;
        bus.PREADY = 1'b0; bus.PRDATA = 32'h1234_5678;
        addr_phase(32'h8, 1'b0, 3'd2);
        step();
        end_addr_phase();
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) begin
                tests++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PSTRB} !== {3'b100, 4'd2, 4'h0}) begin fails++; $display("FAIL rd_setup: got %b want 100_0010_0000", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PSTRB}); end
            end
            if (bus.PENABLE) pen_cnt++;
            if (k == 5) bus.PREADY = 1'b1;
            if (bus.HREADYOUT) begin lat = k; break; end
        end
        tests++; if (pen_cnt != 4) begin fails++; $display("FAIL rd_access_cycles: got %0d want 4", pen_cnt); end
        tests++; if (lat != 6) begin fails++; $display("FAIL rd_latency: got %0d want 6", lat); end
        tests++; if (bus.HRDATA !== 32'h1234_5678) begin fails++; $display("FAIL rd_hrdata: got %0h want 12345678", bus.HRDATA); end
        tests++; if (bus.HRESP !== 1'b0) begin fails++; $display("FAIL rd_hresp: got %0h want 0", bus.HRESP); end
    endtask

    task automatic test_strobes();
        logic [31:0] addrs [6] = '{32'h2, 32'h3, 32'h2, 32'h0, 32'h1, 32'h2};
        logic [2:0]  sizes [6] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2};
        logic [3:0]  estrb [6] = '{4'b0100, 4'b1000, 4'b1100, 4'b0011, 4'b0000, 4'b0000};
        logic        eerr  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0]  strb;
        logic        psel_seen, err;
        int          lat;
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_xfer(addrs[i], 1'b1, sizes[i], 32'h1111_1111 * (i + 1), strb, psel_seen, err, lat);
            tests++; if (strb !== estrb[i]) begin fails++; $display("FAIL strb_%0d: got %b want %b", i, strb, estrb[i]); end
            tests++; if ({err, psel_seen} !== {eerr[i], ~eerr[i]}) begin fails++; $display("FAIL strb_resp_%0d: got err=%0b psel=%0b want err=%0b psel=%0b", i, err, psel_seen, eerr[i], ~eerr[i]); end
            tests++; if (lat != (eerr[i] ? 1 : 3)) begin fails++; $display("FAIL strb_lat_%0d: got %0d want %0d", i, lat, eerr[i] ? 1 : 3); end
        end
        run_xfer(32'h0, 1'b1, 3'd3, 32'h0, strb, psel_seen, err, lat);
        tests++; if ({err, psel_seen} !== 2'b10) begin fails++; $display("FAIL hsize3: got err=%0b psel=%0b want err=1 psel=0", err, psel_seen); end
    endtask

    task automatic test_pslverr_back_to_back();
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b1;
        addr_phase(32'h0, 1'b1, 3'd2);
        step();
        end_addr_phase();
        bus.HWDATA = 32'h5555_AAAA;
        step(); step(); step();
        tests++; if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP} !== 4'b0001) begin fails++; $display("FAIL err1: got %b want 0001", {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP}); end
        step();
        tests++; if ({bus.HREADYOUT, bus.HRESP} !== 2'b11) begin fails++; $display("FAIL err2: got %b want 11", {bus.HREADYOUT, bus.HRESP}); end
        bus.PSLVERR = 1'b0; bus.PRDATA = 32'hCAFE_F00D;
        addr_phase(32'hC, 1'b0, 3'd2);
        step();
        end_addr_phase();
        tests++; if ({bus.HREADYOUT, bus.HRESP} !== 2'b00) begin fails++; $display("FAIL b2b_accept: got %b want 00", {bus.HREADYOUT, bus.HRESP}); end
        step();
        tests++; if ({bus.PSEL, bus.PADDR} !== {1'b1, 4'd3}) begin fails++; $display("FAIL b2b_setup: got %b want 10011", {bus.PSEL, bus.PADDR}); end
        step(); step();
        tests++; if ({bus.HREADYOUT, bus.HRESP} !== 2'b10) begin fails++; $display("FAIL b2b_done: got %b want 10", {bus.HREADYOUT, bus.HRESP}); end
        tests++; if (bus.HRDATA !== 32'hCAFE_F00D) begin fails++; $display("FAIL b2b_hrdata: got %0h want cafef00d", bus.HRDATA); end
    endtask

    task automatic test_reset_mid_access();
        bus.PREADY = 1'b0;
        addr_phase(32'h4, 1'b0, 3'd2);
        step();
        end_addr_phase();
        step(); step();
        tests++; if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin fails++; $display("FAIL rstmid_in_access: got %b want 11", {bus.PSEL, bus.PENABLE}); end
        HRESETn = 1'b0;
        step();
        HRESETn = 1'b1;
        tests++; if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP} !== 4'b0010) begin fails++; $display("FAIL rstmid_ctl: got %b want 0010", {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP}); end
        tests++; if (bus.HRDATA !== 32'h0) begin fails++; $display("FAIL rstmid_hrdata: got %0h want 0", bus.HRDATA); end
        bus.PREADY = 1'b1;
        step();
        tests++; if ({bus.PSEL, bus.HREADYOUT} !== 2'b01) begin fails++; $display("FAIL rstmid_abandoned: got %b want 01", {bus.PSEL, bus.HREADYOUT}); end
    endtask

`ifdef APB_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int pen_cnt = 0;
        int err1_k = 0;
        int done_k = 0;
        bus.PREADY = 1'b0; bus.PRDATA = 32'hDEAD_BEEF;
        addr_phase(32'h4, 1'b0, 3'd2);
        step();
        end_addr_phase();
        for (int k = 1; k <= 20; k++) begin
            step();
            if (bus.PENABLE) pen_cnt++;
            if (bus.HRESP && !bus.HREADYOUT && err1_k == 0) err1_k = k;
            if (bus.HREADYOUT) begin done_k = k; break; end
        end
        tests++; if (pen_cnt != 4) begin fails++; $display("FAIL to_access_cycles: got %0d want 4", pen_cnt); end
        tests++; if (err1_k != 6) begin fails++; $display("FAIL to_err1_cycle: got %0d want 6", err1_k); end
        tests++; if (done_k != 7 || bus.HRESP !== 1'b1) begin fails++; $display("FAIL to_err2: got k=%0d hresp=%0b want k=7 hresp=1", done_k, bus.HRESP); end
        tests++; if (bus.HRDATA !== 32'h0) begin fails++; $display("FAIL to_hrdata: got %0h want 0", bus.HRDATA); end
        bus.PREADY = 1'b1;
        step();
    endtask
`else
    task automatic test_no_timeout();
        bus.PREADY = 1'b0;
        addr_phase(32'h4, 1'b1, 3'd2);
        step();
        end_addr_phase();
        bus.HWDATA = 32'h0BAD_CAFE;
        for (int k = 0; k < 300; k++) step();
        tests++; if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP} !== 4'b1100) begin fails++; $display("FAIL nto_waiting: got %b want 1100", {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP}); end
        bus.PREADY = 1'b1;
        step();
        tests++; if ({bus.PSEL, bus.HREADYOUT, bus.HRESP} !== 3'b010) begin fails++; $display("FAIL nto_done: got %b want 010", {bus.PSEL, bus.HREADYOUT, bus.HRESP}); end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_busy();
        test_word_write();
        test_read_wait();
        test_strobes();
        test_pslverr_back_to_back();
        test_reset_mid_access();
`ifdef APB_BRIDGE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
